// File: rtl/pattern_sequencer.sv
// pattern_sequencer: 16-step tone pattern player for the tone path.
// Holds a register-based pattern store and starts playback on a
// synchronized nStart press. Each Step pulse advances one entry, and the
// run ends after a latched number of passes. Select/Play feed the audio
// generators and the output-channel gating.
module pattern_sequencer #(
  parameter  int STEPS  = 16,
  parameter  int TONES  = 12,
  parameter  int LOOP_W = 7,
  localparam int IW     = $clog2(STEPS)
) (
  input  logic              CLOCK_50,
  input  logic              nReset,
  input  logic              nStart,
  input  logic              Stop,
  input  logic              Step,
  input  logic [LOOP_W-1:0] Loops,
  input  logic [IW-1:0]     Last,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_addr,
  input  logic [TONES-1:0]  wr_data,
  output logic [TONES-1:0]  Select,
  output logic              Play,
  output logic [IW-1:0]     step_idx,
  output logic [LOOP_W-1:0] loop_cnt,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_PLAY = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              prev_q, prev_d;
  logic [LOOP_W-1:0] loops_lat_q, loops_lat_d;
  logic [IW-1:0]     last_lat_q, last_lat_d;
  logic [LOOP_W-1:0] loop_cnt_q, loop_cnt_d;
  logic [IW-1:0]     step_idx_q, step_idx_d;
  logic [TONES-1:0]  select_q, select_d;
  logic              play_q, play_d;
  logic              done_q, done_d;
  logic [TONES-1:0]  pattern_q [STEPS];
  logic [TONES-1:0]  pattern_d [STEPS];

  logic              start_s;
  logic [IW-1:0]     next_idx_s;
  logic [LOOP_W:0]   loop_nxt_s;
  logic [LOOP_W:0]   loops_ext_s;

  // Start is a falling edge of the synchronized button; extra bit on the loop
  // compare keeps Loops at its maximum from wrapping.
  assign start_s     = prev_q & ~sync2_q;
  assign next_idx_s  = step_idx_q + {{(IW-1){1'b0}}, 1'b1};
  assign loop_nxt_s  = {1'b0, loop_cnt_q} + {{LOOP_W{1'b0}}, 1'b1};
  assign loops_ext_s = {1'b0, loops_lat_q};

  // Pattern store next value: write port is live in every state.
  always_comb begin
    pattern_d = pattern_q;
    if (wr_en) begin
      pattern_d[wr_addr] = wr_data;
    end else begin
      pattern_d = pattern_q;
    end
  end

  // Synchronizer chain and edge register for the asynchronous button.
  always_comb begin
    sync1_d = nStart;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // FSM next-state and datapath; reads of pattern_q see pre-write values.
  always_comb begin
    state_d     = state_q;
    loops_lat_d = loops_lat_q;
    last_lat_d  = last_lat_q;
    loop_cnt_d  = loop_cnt_q;
    step_idx_d  = step_idx_q;
    select_d    = select_q;
    play_d      = play_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        play_d   = 1'b0;
        select_d = {TONES{1'b0}};
        if (start_s && (Loops != {LOOP_W{1'b0}})) begin
          loops_lat_d = Loops;
          last_lat_d  = Last;
          loop_cnt_d  = {LOOP_W{1'b0}};
          step_idx_d  = {IW{1'b0}};
          state_d     = S_ARM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARM: begin
        if (Stop) begin
          state_d    = S_IDLE;
          play_d     = 1'b0;
          select_d   = {TONES{1'b0}};
          step_idx_d = {IW{1'b0}};
        end else if (Step) begin
          select_d   = pattern_q[0];
          play_d     = 1'b1;
          step_idx_d = {IW{1'b0}};
          state_d    = S_PLAY;
        end else begin
          state_d = S_ARM;
        end
      end
      S_PLAY: begin
        if (Stop) begin
          state_d    = S_IDLE;
          play_d     = 1'b0;
          select_d   = {TONES{1'b0}};
          step_idx_d = {IW{1'b0}};
        end else if (Step) begin
          if (step_idx_q < last_lat_q) begin
            step_idx_d = next_idx_s;
            select_d   = pattern_q[next_idx_s];
          end else if (loop_nxt_s < loops_ext_s) begin
            loop_cnt_d = loop_nxt_s[LOOP_W-1:0];
            step_idx_d = {IW{1'b0}};
            select_d   = pattern_q[0];
          end else begin
            // Final step of the final pass: Done and Play fall together.
            state_d    = S_DONE;
            done_d     = 1'b1;
            play_d     = 1'b0;
            select_d   = {TONES{1'b0}};
            step_idx_d = {IW{1'b0}};
          end
        end else begin
          state_d = S_PLAY;
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        play_d     = 1'b0;
        select_d   = {TONES{1'b0}};
        step_idx_d = {IW{1'b0}};
      end
      default: begin
        state_d    = S_IDLE;
        play_d     = 1'b0;
        select_d   = {TONES{1'b0}};
        step_idx_d = {IW{1'b0}};
      end
    endcase
  end

  // State, datapath and pattern registers; reset clears everything.
  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      loops_lat_q <= {LOOP_W{1'b0}};
      last_lat_q  <= {IW{1'b0}};
      loop_cnt_q  <= {LOOP_W{1'b0}};
      step_idx_q  <= {IW{1'b0}};
      select_q    <= {TONES{1'b0}};
      play_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < STEPS; i++) begin
        pattern_q[i] <= {TONES{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      loops_lat_q <= loops_lat_d;
      last_lat_q  <= last_lat_d;
      loop_cnt_q  <= loop_cnt_d;
      step_idx_q  <= step_idx_d;
      select_q    <= select_d;
      play_q      <= play_d;
      done_q      <= done_d;
      for (int i = 0; i < STEPS; i++) begin
        pattern_q[i] <= pattern_d[i];
      end
    end
  end

  assign Select   = select_q;
  assign Play     = play_q;
  assign step_idx = step_idx_q;
  assign loop_cnt = loop_cnt_q;
  assign Done     = done_q;
  assign Busy     = (state_q == S_ARM) || (state_q == S_PLAY);

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed testbench for pattern_sequencer with hand-computed expectations.
module tb_pattern_sequencer;

  logic        clk;
  logic        nReset;
  logic        nStart;
  logic        Stop;
  logic        Step;
  logic [6:0]  Loops;
  logic [3:0]  Last;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [11:0] wr_data;
  logic [11:0] Select;
  logic        Play;
  logic [3:0]  step_idx;
  logic [6:0]  loop_cnt;
  logic        Busy;
  logic        Done;

  int checks;
  int failures;

  pattern_sequencer dut (
    .CLOCK_50 (clk),
    .nReset   (nReset),
    .nStart   (nStart),
    .Stop     (Stop),
    .Step     (Step),
    .Loops    (Loops),
    .Last     (Last),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .Select   (Select),
    .Play     (Play),
    .step_idx (step_idx),
    .loop_cnt (loop_cnt),
    .Busy     (Busy),
    .Done     (Done)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle Step pulse; outputs are inspected right after the sampling edge.
  task automatic step_pulse();
    Step = 1'b1;
    tick();
    Step = 1'b0;
  endtask

  // Press nStart; Busy must rise exactly after the third edge.
  task automatic press(input logic expect_busy);
    nStart = 1'b0;
    tick();
    tick();
    check("start_latency_2", {31'd0, Busy}, 32'd0);
    tick();
    check("start_latency_3", {31'd0, Busy}, {31'd0, expect_busy});
    nStart = 1'b1;
    tick();
    tick();
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [11:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nReset   = 1'b0;
    nStart   = 1'b1;
    Stop     = 1'b0;
    Step     = 1'b0;
    Loops    = 7'd0;
    Last     = 4'd0;
    wr_en    = 1'b0;
    wr_addr  = 4'd0;
    wr_data  = 12'd0;

    // Reset values.
    #12;
    check("rst_select", {20'd0, Select}, 32'd0);
    check("rst_play", {31'd0, Play}, 32'd0);
    check("rst_step_idx", {28'd0, step_idx}, 32'd0);
    check("rst_loop_cnt", {25'd0, loop_cnt}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    tick();
    nReset = 1'b1;
    tick();

    // Run 1: pattern[i] = i+1, Last=15, Loops=1.
    for (int i = 0; i < 16; i++) begin
      write_entry(i[3:0], 12'(i + 1));
    end
    Loops = 7'd1;
    Last  = 4'd15;
    press(1'b1);
    for (int k = 0; k < 16; k++) begin
      step_pulse();
      check("r1_select", {20'd0, Select}, 32'(k + 1));
      check("r1_step_idx", {28'd0, step_idx}, 32'(k));
      check("r1_play", {31'd0, Play}, 32'd1);
      tick();
    end
    step_pulse();
    check("r1_done", {31'd0, Done}, 32'd1);
    check("r1_done_play", {31'd0, Play}, 32'd0);
    check("r1_done_select", {20'd0, Select}, 32'd0);
    check("r1_done_busy", {31'd0, Busy}, 32'd0);
    tick();
    check("r1_done_width", {31'd0, Done}, 32'd0);
    tick();

    // Run 2: Last=2, Loops=3; inputs changed mid-run must not matter.
    write_entry(4'd0, 12'h001);
    write_entry(4'd1, 12'h002);
    write_entry(4'd2, 12'h004);
    Loops = 7'd3;
    Last  = 4'd2;
    press(1'b1);
    Loops = 7'd0;
    Last  = 4'd0;
    for (int p = 0; p < 3; p++) begin
      for (int s = 0; s < 3; s++) begin
        step_pulse();
        check("r2_select", {20'd0, Select}, 32'd1 << s);
        check("r2_loop_cnt", {25'd0, loop_cnt}, 32'(p));
        check("r2_play", {31'd0, Play}, 32'd1);
        tick();
      end
    end
    step_pulse();
    check("r2_done", {31'd0, Done}, 32'd1);
    check("r2_play_fall", {31'd0, Play}, 32'd0);
    tick();
    check("r2_done_width", {31'd0, Done}, 32'd0);
    tick();

    // Run 3: Loops=0 start is ignored.
    Loops = 7'd0;
    Last  = 4'd3;
    press(1'b0);
    check("r3_busy", {31'd0, Busy}, 32'd0);
    step_pulse();
    check("r3_play", {31'd0, Play}, 32'd0);
    check("r3_select", {20'd0, Select}, 32'd0);
    tick();

    // Run 4: Stop at step_idx 7 with Last=15, Loops=5.
    Loops = 7'd5;
    Last  = 4'd15;
    press(1'b1);
    for (int k = 0; k < 8; k++) begin
      step_pulse();
      tick();
    end
    check("r4_idx_before_stop", {28'd0, step_idx}, 32'd7);
    check("r4_select_before_stop", {20'd0, Select}, 32'd8);
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    check("r4_stop_play", {31'd0, Play}, 32'd0);
    check("r4_stop_select", {20'd0, Select}, 32'd0);
    check("r4_stop_idx", {28'd0, step_idx}, 32'd0);
    check("r4_stop_busy", {31'd0, Busy}, 32'd0);
    check("r4_stop_done", {31'd0, Done}, 32'd0);
    tick();
    check("r4_stop_done_later", {31'd0, Done}, 32'd0);
    step_pulse();
    check("r4_step_after_stop", {31'd0, Play}, 32'd0);
    tick();

    // Run 5: write collision on the entry about to be read.
    Loops = 7'd2;
    Last  = 4'd3;
    press(1'b1);
    step_pulse();
    check("r5_first", {20'd0, Select}, 32'h001);
    tick();
    wr_en   = 1'b1;
    wr_addr = 4'd1;
    wr_data = 12'hABC;
    step_pulse();
    wr_en   = 1'b0;
    check("r5_old_value", {20'd0, Select}, 32'h002);
    tick();
    step_pulse();
    check("r5_idx2", {20'd0, Select}, 32'h004);
    tick();
    step_pulse();
    check("r5_idx3", {20'd0, Select}, 32'h004);
    tick();
    step_pulse();
    check("r5_wrap", {20'd0, Select}, 32'h001);
    check("r5_loop_cnt", {25'd0, loop_cnt}, 32'd1);
    tick();
    step_pulse();
    check("r5_new_value", {20'd0, Select}, 32'hABC);

    // Run 6: asynchronous reset mid-PLAY, between edges.
    #2;
    nReset = 1'b0;
    #1;
    check("r6_async_play", {31'd0, Play}, 32'd0);
    check("r6_async_select", {20'd0, Select}, 32'd0);
    check("r6_async_busy", {31'd0, Busy}, 32'd0);
    tick();
    nReset = 1'b1;
    tick();
    check("r6_idle_busy", {31'd0, Busy}, 32'd0);
    Loops = 7'd1;
    Last  = 4'd1;
    press(1'b1);
    step_pulse();
    check("r6_pattern_cleared", {20'd0, Select}, 32'd0);
    check("r6_play", {31'd0, Play}, 32'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
